// File: rtl/key_debounce_pkg.sv
// Shared helpers for the key debounce block: counter width sizing and the FSM state encoding.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        DOWN      = 2'd2,
        REL_FLT   = 2'd3
    } state_t;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int get_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button and classifies presses into short/long events.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int CNT_NUM  = 1_000_000,
    parameter int LONG_NUM = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_short,
    output logic key_long,
    output logic led_en
);

    localparam int FW = get_width(CNT_NUM);
    localparam int HW = get_width(LONG_NUM);
    localparam logic [FW-1:0] FLT_LAST  = FW'(CNT_NUM - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_NUM - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_NUM - 2);

    logic          key_s;
    state_t        state;
    logic [FW-1:0] flt_cnt;
    logic [HW-1:0] hold_cnt;
    logic          long_seen;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_n),
        .q   (key_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            flt_cnt     <= '0;
            hold_cnt    <= '0;
            long_seen   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_short   <= 1'b0;
            key_long    <= 1'b0;
            led_en      <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_short   <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state   <= PRESS_FLT;
                        flt_cnt <= '0;
                    end
                end
                PRESS_FLT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (flt_cnt == FLT_LAST) begin
                        state     <= DOWN;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        flt_cnt <= flt_cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_s) begin
                        state   <= REL_FLT;
                        flt_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Saturating count: the long event fires only on the step into the last value.
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_PRE) begin
                            key_long  <= 1'b1;
                            long_seen <= 1'b1;
                        end
                    end
                end
                REL_FLT: begin
                    if (!key_s) begin
                        state <= DOWN;
                    end else if (flt_cnt == FLT_LAST) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        long_seen   <= 1'b0;
                        if (!long_seen) begin
                            key_short <= 1'b1;
                            led_en    <= ~led_en;
                        end
                    end else begin
                        flt_cnt <= flt_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
